// File: rtl/bnn_pkg.sv
// Shared constants and FSM state encoding for the BNN output-feature-map path.
package bnn_pkg;

  localparam int WORD_WIDTH_DEF             = 32;
  localparam int OFMAPS_BRAM_ADDR_WIDTH_DEF = 12;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN   = 2'd0;
  localparam state_t ST_FLUSH = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/bit_shift_acc.sv
// Bit accumulator: shift register plus bit counter, emitting full or flush-aligned words.
// OFMAP_PACK_MSB_FIRST_EN selects MSB-first packing; the default build packs LSB-first.
module bit_shift_acc
  import bnn_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_accept,
  input  logic                  i_bit,
  input  logic                  i_clear,
  output logic [WORD_WIDTH-1:0] o_word,
  output logic                  o_word_full,
  output logic                  o_has_bits
);

  localparam int CW = $clog2(WORD_WIDTH) + 1;

  logic [WORD_WIDTH-1:0] shift_q, shift_d, shift_inc;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;

  // o_word already includes the bit accepted this cycle, so a word can be written next cycle.
  always_comb begin
    cnt_inc   = cnt_q + CW'(i_accept);
    shift_inc = shift_q;
    if (i_accept) begin
`ifdef OFMAP_PACK_MSB_FIRST_EN
      shift_inc = (shift_q << 1) | WORD_WIDTH'(i_bit);
`else
      shift_inc = shift_q | (WORD_WIDTH'(i_bit) << cnt_q);
`endif
    end
    o_word_full = (cnt_inc == CW'(WORD_WIDTH));
    o_has_bits  = (cnt_inc != '0);
`ifdef OFMAP_PACK_MSB_FIRST_EN
    // Left-align a partial word so padding zeros land in the low bits.
    o_word = shift_inc << (CW'(WORD_WIDTH) - cnt_inc);
`else
    o_word = shift_inc;
`endif
    if (i_clear || o_word_full) begin
      shift_d = '0;
      cnt_d   = '0;
    end else begin
      shift_d = shift_inc;
      cnt_d   = cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/ofmap_bit_packer.sv
// Packs the binarized activation stream into BRAM words and reports per-layer word counts.
// Packing order follows bit_shift_acc (macro OFMAP_PACK_MSB_FIRST_EN).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RUN   | accepting bits; i_last schedules the flush write (if any)
// ST_FLUSH | partial word (if any) is on the BRAM port; stray bits dropped
// ST_DONE  | o_layer_done/o_word_count presented; counters rewound
module ofmap_bit_packer
  import bnn_pkg::*;
#(
  parameter int WORD_WIDTH             = WORD_WIDTH_DEF,
  parameter int OFMAPS_BRAM_ADDR_WIDTH = OFMAPS_BRAM_ADDR_WIDTH_DEF,
  parameter int BASE_ADDR              = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_data,
  input  logic                              i_valid,
  input  logic                              i_last,
  output logic                              bram_we,
  output logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] bram_addr,
  output logic [WORD_WIDTH-1:0]             bram_wdata,
  output logic                              o_layer_done,
  output logic [OFMAPS_BRAM_ADDR_WIDTH:0]   o_word_count,
  output logic                              o_overflow,
  output logic                              o_proto_err
);

  localparam int AW = OFMAPS_BRAM_ADDR_WIDTH;
  localparam logic [AW-1:0] ADDR_BASE = AW'(BASE_ADDR);
  localparam logic [AW-1:0] ADDR_LAST = '1;

  state_t              state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                cap_full_q, cap_full_d;
  logic [AW:0]         count_q, count_d;
  logic                bram_we_q, bram_we_d;
  logic [AW-1:0]       bram_addr_q, bram_addr_d;
  logic [WORD_WIDTH-1:0] bram_wdata_q, bram_wdata_d;
  logic                layer_done_q, layer_done_d;
  logic [AW:0]         word_count_q, word_count_d;
  logic                overflow_q, overflow_d;
  logic                proto_err_q, proto_err_d;

  logic                  acc_accept, acc_clear, acc_full, acc_has_bits, write_req;
  logic [WORD_WIDTH-1:0] acc_word;

  assign acc_accept = (state_q == ST_RUN) && i_valid;
  // i_last hands the accumulated bits to the flush write, so the accumulator empties at once.
  assign acc_clear  = ((state_q == ST_RUN) && i_last) || (state_q == ST_DONE);

  bit_shift_acc #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_acc (
    .clk         (clk),
    .rst         (rst),
    .i_accept    (acc_accept),
    .i_bit       (i_data),
    .i_clear     (acc_clear),
    .o_word      (acc_word),
    .o_word_full (acc_full),
    .o_has_bits  (acc_has_bits)
  );

  assign write_req = (state_q == ST_RUN) && (acc_full || (i_last && acc_has_bits));

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cap_full_d   = cap_full_q;
    count_d      = count_q;
    bram_we_d    = 1'b0;
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;
    layer_done_d = 1'b0;
    word_count_d = '0;
    overflow_d   = overflow_q;
    proto_err_d  = proto_err_q;

    case (state_q)
      ST_RUN: begin
        if (i_last) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        state_d      = ST_DONE;
        layer_done_d = 1'b1;
        word_count_d = count_q;
      end
      ST_DONE: begin
        state_d    = ST_RUN;
        addr_d     = ADDR_BASE;
        cap_full_d = 1'b0;
        count_d    = '0;
      end
      default: state_d = ST_RUN;
    endcase

    if (((state_q == ST_FLUSH) || (state_q == ST_DONE)) && i_valid) proto_err_d = 1'b1;

    // Once the top address has been written the address holds and later writes are dropped.
    if (write_req) begin
      if (cap_full_q) begin
        overflow_d = 1'b1;
      end else begin
        bram_we_d    = 1'b1;
        bram_addr_d  = addr_q;
        bram_wdata_d = acc_word;
        count_d      = count_q + (AW + 1)'(1);
        if (addr_q == ADDR_LAST) cap_full_d = 1'b1;
        else                     addr_d     = addr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      addr_q       <= ADDR_BASE;
      cap_full_q   <= 1'b0;
      count_q      <= '0;
      bram_we_q    <= 1'b0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
      layer_done_q <= 1'b0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cap_full_q   <= cap_full_d;
      count_q      <= count_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
      layer_done_q <= layer_done_d;
      word_count_q <= word_count_d;
      overflow_q   <= overflow_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign bram_we      = bram_we_q;
  assign bram_addr    = bram_addr_q;
  assign bram_wdata   = bram_wdata_q;
  assign o_layer_done = layer_done_q;
  assign o_word_count = word_count_q;
  assign o_overflow   = overflow_q;
  assign o_proto_err  = proto_err_q;

endmodule

// File: tb/tb_ofmap_bit_packer.sv
// Scoreboard bench for ofmap_bit_packer: a 32-bit/AW=12 instance and an 8-bit/AW=2 overflow instance.
// Expected values honour OFMAP_PACK_MSB_FIRST_EN when it is defined.
module tb_ofmap_bit_packer;

  localparam int W  = 32;
  localparam int AW = 12;
  localparam int SW  = 8;
  localparam int SAW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic i_data, i_valid, i_last;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [W-1:0]  bram_wdata;
  logic          o_layer_done;
  logic [AW:0]   o_word_count;
  logic          o_overflow, o_proto_err;

  logic s_data, s_valid, s_last;
  logic           s_we;
  logic [SAW-1:0] s_addr;
  logic [SW-1:0]  s_wdata;
  logic           s_done;
  logic [SAW:0]   s_count;
  logic           s_overflow, s_proto_err;

  ofmap_bit_packer #(.WORD_WIDTH(W), .OFMAPS_BRAM_ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .o_layer_done(o_layer_done), .o_word_count(o_word_count),
    .o_overflow(o_overflow), .o_proto_err(o_proto_err)
  );

  ofmap_bit_packer #(.WORD_WIDTH(SW), .OFMAPS_BRAM_ADDR_WIDTH(SAW), .BASE_ADDR(0)) dut_small (
    .clk(clk), .rst(rst), .i_data(s_data), .i_valid(s_valid), .i_last(s_last),
    .bram_we(s_we), .bram_addr(s_addr), .bram_wdata(s_wdata),
    .o_layer_done(s_done), .o_word_count(s_count),
    .o_overflow(s_overflow), .o_proto_err(s_proto_err)
  );

  int checks = 0;
  int errors = 0;

  logic [AW+W-1:0] wr_q[$];
  int              done_q[$];

  // reference model of the 32-bit instance
  int            m_st = 0;
  int            m_cnt = 0;
  int            m_count = 0;
  logic [AW-1:0] m_addr = '0;
  logic [W-1:0]  m_word = '0;

  int s_wr_cnt = 0;
  int s_done_cnt = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word();
    wr_q.push_back({m_addr, m_word});
    m_addr  = m_addr + AW'(1);
    m_count = m_count + 1;
    m_word  = '0;
    m_cnt   = 0;
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_count = 0; m_addr = '0; m_word = '0;
  endtask

  task automatic step(input logic v, input logic d, input logic l);
    i_valid = v; i_data = d; i_last = l;
    case (m_st)
      0: begin
        if (v) begin
`ifdef OFMAP_PACK_MSB_FIRST_EN
          m_word[W-1-m_cnt] = d;
`else
          m_word[m_cnt] = d;
`endif
          m_cnt = m_cnt + 1;
          if (m_cnt == W) push_word();
        end
        if (l) begin
          if (m_cnt > 0) push_word();
          done_q.push_back(m_count);
          m_st = 1;
        end
      end
      1: m_st = 2;
      default: begin
        m_st = 0; m_addr = '0; m_count = 0;
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (bram_we) begin
      chk("wr_expected", (wr_q.size() != 0), 1);
      if (wr_q.size() != 0) begin
        logic [AW+W-1:0] e;
        e = wr_q.pop_front();
        chk("wr_addr", bram_addr, e[AW+W-1:W]);
        chk("wr_data", bram_wdata, e[W-1:0]);
      end
    end
    if (o_layer_done) begin
      chk("done_expected", (done_q.size() != 0), 1);
      if (done_q.size() != 0) chk("done_count", o_word_count, done_q.pop_front());
    end
    if (s_we) begin
      chk("s_wr_addr", s_addr, s_wr_cnt);
      chk("s_wr_data", s_wdata, 8'hFF);
      s_wr_cnt++;
    end
    if (s_done) s_done_cnt = int'(s_count);
  end

  initial begin
    logic [W-1:0] exp_w2;
`ifdef OFMAP_PACK_MSB_FIRST_EN
    exp_w2 = 32'hFF00_0000;
`else
    exp_w2 = 32'h0000_00FF;
`endif
    rst = 1'b1;
    i_valid = 1'b0; i_data = 1'b0; i_last = 1'b0;
    s_valid = 1'b0; s_data = 1'b0; s_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {bram_we, bram_addr, bram_wdata, o_layer_done, o_word_count, o_overflow, o_proto_err}, '0);
    chk("rst_small", {s_we, s_addr, s_wdata, s_done, s_count, s_overflow, s_proto_err}, '0);
    rst = 1'b0;
    step(0, 0, 0);

    // alternating bits, i_last two cycles after the final bit
    for (int i = 0; i < 32; i++) step(1, logic'(i % 2 == 0), 0);
    chk("t1_we_at_T1", bram_we, 1);
    step(0, 0, 0);
    step(0, 0, 1);
    chk("t1_no_flush_write", bram_we, 0);
    chk("t1_done_not_early", o_layer_done, 0);
    step(0, 0, 0);
    chk("t1_done_at_T2", o_layer_done, 1);
    chk("t1_count", o_word_count, 1);
    step(0, 0, 0);

    // 40 ones with i_last on the final bit
    for (int i = 0; i < 40; i++) step(1, 1, logic'(i == 39));
    chk("t2_flush_we", bram_we, 1);
    chk("t2_flush_addr", bram_addr, 1);
    chk("t2_flush_data", bram_wdata, exp_w2);
    step(0, 0, 0);
    chk("t2_done", o_layer_done, 1);
    chk("t2_count", o_word_count, 2);
    step(0, 0, 0);

    // empty layer
    step(0, 0, 1);
    chk("t3_no_write", bram_we, 0);
    step(0, 0, 0);
    chk("t3_done", o_layer_done, 1);
    chk("t3_count", o_word_count, 0);
    step(0, 0, 0);

    // layer A (33 random bits) then layer B starting at A's last+3
    for (int i = 0; i < 33; i++) step(1, logic'($urandom_range(0, 1)), logic'(i == 32));
    step(0, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < 32; i++) step(1, logic'($urandom_range(0, 1)), logic'(i == 31));
    chk("t4_b_we", bram_we, 1);
    chk("t4_b_addr", bram_addr, 0);
    step(0, 0, 0);
    chk("t4_b_done", o_layer_done, 1);
    step(0, 0, 0);

    // i_valid (and a stray i_last) during FLUSH
    for (int i = 0; i < 4; i++) step(1, 1, logic'(i == 3));
    chk("t5_proto_clear", o_proto_err, 0);
    step(1, 1, 1);
    chk("t5_proto_set", o_proto_err, 1);
    step(0, 0, 0);
    for (int i = 0; i < 32; i++) step(1, 0, logic'(i == 31));
    step(0, 0, 0);
    step(0, 0, 0);
    chk("t5_proto_sticky", o_proto_err, 1);

    // overflow on the 8-bit, 4-word instance
    for (int i = 0; i < 40; i++) begin
      s_valid = 1'b1; s_data = 1'b1; s_last = logic'(i == 39);
      step(0, 0, 0);
    end
    s_valid = 1'b0; s_data = 1'b0; s_last = 1'b0;
    chk("ov_flag", s_overflow, 1);
    chk("ov_no_we", s_we, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("ov_writes", s_wr_cnt, 4);
    chk("ov_done_count", s_done_cnt, 4);
    chk("ov_sticky", s_overflow, 1);

    // reset mid-layer discards the partial word
    for (int i = 0; i < 10; i++) step(1, 1, 0);
    chk("t6_nothing_pending", wr_q.size(), 0);
    rst = 1'b1;
    i_valid = 1'b0; i_data = 1'b0; i_last = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("t6_outputs", {bram_we, bram_addr, bram_wdata, o_layer_done, o_word_count, o_overflow, o_proto_err}, '0);
    chk("t6_small_flags", {s_overflow, s_proto_err}, '0);
    repeat (3) step(0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, logic'(i < 3), logic'(i == 7));
    chk("t6_partial_addr", bram_addr, 0);
    step(0, 0, 0);
    chk("t6_count", o_word_count, 1);
    repeat (2) step(0, 0, 0);

    chk("end_wr_q_empty", wr_q.size(), 0);
    chk("end_done_q_empty", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
